mem_rmw_seq: RTL and testbench
==============================

// Module: mem_rmw_seq
// PURPOSE
//  Sequencer between the CPU byte-lane memory port and a 16-bit word-wide synchronous RAM.
//  Turns one CPU request (word or byte, read or write) into RAM cycles.
//  Byte writes become read-modify-write; byte reads are lane-extracted.
//  Exactly one cpu_ack is returned per accepted request.
// PARAMETERS
//  AW       16  CPU byte-address width; RAM word address is cpu_addr[AW-1:1]
//  RAM_LAT  1   cycles from ram_en (read) to ram_rdata valid; legal 1..8
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  reset      in   1      synchronous, active-high
//  cpu_req    in   1      request strobe, sampled only in IDLE
//  cpu_addr   in   AW     byte address; bit 0 ignored (lanes chosen by cpu_be)
//  cpu_be     in   2      byte enables: [0]=bits 7:0, [1]=bits 15:8
//  cpu_we     in   1      1=write, 0=read
//  cpu_wdata  in   16     write data, lane-aligned (unshifted)
//  cpu_rdata  out  16     read result, registered
//  cpu_ack    out  1      one-cycle completion pulse
//  cpu_busy   out  1      1 whenever state != IDLE
//  ram_en     out  1      RAM access strobe
//  ram_we     out  1      RAM write (qualified by ram_en)
//  ram_addr   out  AW-1   RAM word address
//  ram_wdata  out  16     RAM write data
//  ram_rdata  in   16     RAM read data
// BEHAVIOUR
//  Reset: state=IDLE; cpu_rdata=0; cpu_ack, cpu_busy, ram_en, ram_we = 0; ram_addr, ram_wdata = 0.
//  IDLE: if cpu_req, latch addr/be/we/wdata at the edge. cpu_req while busy is ignored, not queued.
//  Next state from IDLE:
//   - be==00 -> ACK (no RAM access, cpu_rdata unchanged)
//   - we && be==11 -> WRITE (no read)
//   - otherwise -> READ
//  READ: ram_en=1, ram_we=0 for one cycle -> WAIT.
//  WAIT: lasts RAM_LAT cycles (3-bit counter); on its last cycle sample ram_rdata into merge reg.
//   - Read: cpu_rdata <= be11: word; be01: {8'h00,rd[7:0]}; be10: {8'h00,rd[15:8]}. Then -> ACK.
//   - Write: -> WRITE.
//  WRITE: ram_en=1, ram_we=1 for one cycle -> ACK.
//   - ram_wdata lane i = be[i] ? cpu_wdata lane i : merge lane i.
//   - Word write uses cpu_wdata directly.
//  ACK: cpu_ack=1 for one cycle; cpu_rdata is valid in this cycle and holds until the next read completes -> IDLE.
//  ram_addr holds latched word address for the whole transaction. ram_en/ram_we are high only in READ/WRITE.
//  Latency, acceptance edge = cycle 0 (ack cycle):
//   - be00: 1
//   - word write: 2
//   - read: 2+RAM_LAT
//   - byte write: 3+RAM_LAT
//  New request may be accepted in the cycle after ACK (back-to-back, one idle cycle).
//  Reset mid-operation: return to IDLE next edge, no ack, no further RAM strobes.
//   - RMW aborted before WRITE leaves RAM unmodified.
//  cpu_rdata is never altered by writes.
// TESTING
//  1 RAM[2]=16'h1234; write addr=4 be=01 wdata=16'h00bb -> RAM[2]=16'h12bb; ack 4 cycles after accept (RAM_LAT=1).
//  2 RAM[2]=16'h1234; write be=10 wdata=16'hcc00 -> RAM[2]=16'hcc34; exactly one ram_we pulse.
//  3 RAM[2]=16'haabb; read be=10 -> cpu_rdata=16'h00aa; be=01 -> 16'h00bb; be=11 -> 16'haabb; ack at cycle 3.
//  4 Word write addr=6 be=11 wdata=16'hbeef -> no ram read strobe, RAM[3]=16'hbeef, ack cycle 2; be=00 -> ack cycle 1, no ram_en.
//  5 RAM_LAT=3: byte write -> ram_en read at cycle 1, write at cycle 5, ack cycle 6; cpu_req pulses while busy ignored.
//  6 reset asserted during WAIT of byte write -> no ack, no ram_we, RAM unchanged, all outputs 0 after edge.

Source files
------------

// File: rtl/mem_rmw_seq.sv
// CPU byte-lane port to 16-bit word RAM sequencer; byte writes become read-modify-write.
// Ack latency: be00=1, word write=2, read=2+RAM_LAT, byte write=3+RAM_LAT; cpu_busy stalls the CPU, cpu_req while busy is dropped.
module mem_rmw_seq #(
   parameter int AW      = 16,
   parameter int RAM_LAT = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic [AW-1:0] cpu_addr,
   input  logic [1:0]    cpu_be,
   input  logic          cpu_we,
   input  logic [15:0]   cpu_wdata,
   output logic [15:0]   cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_busy,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-2:0] ram_addr,
   output logic [15:0]   ram_wdata,
   input  logic [15:0]   ram_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_ACK} state_t;

   localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [1:0]    be_q, be_d;
   logic          we_q, we_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          ack_q, ack_d;
   logic          busy_q, busy_d;
   logic          ram_en_q, ram_en_d;
   logic          ram_we_q, ram_we_d;
   logic [AW-2:0] addr_q, addr_d;
   logic [15:0]   ram_wdata_q, ram_wdata_d;
   logic [15:0]   lane_mask;
   logic          unused_addr_lsb;

   assign unused_addr_lsb = cpu_addr[0];
   assign lane_mask       = {{8{be_q[1]}}, {8{be_q[0]}}};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      be_d        = be_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      addr_d      = addr_q;
      ram_wdata_d = ram_wdata_q;
      ack_d       = 1'b0;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cpu_req) begin
               be_d    = cpu_be;
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
               addr_d  = cpu_addr[AW-1:1];
               if (cpu_be == 2'b00) begin
                  state_d = S_ACK;
                  ack_d   = 1'b1;
               end else if (cpu_we && cpu_be == 2'b11) begin
                  state_d     = S_WRITE;
                  ram_en_d    = 1'b1;
                  ram_we_d    = 1'b1;
                  ram_wdata_d = cpu_wdata;
               end else begin
                  state_d  = S_READ;
                  ram_en_d = 1'b1;
               end
            end
         end
         S_READ: begin
            state_d = S_WAIT;
            cnt_d   = LAT_LAST;
         end
         S_WAIT: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else if (we_q) begin
               // the merge lands straight in the write-data register
               state_d     = S_WRITE;
               ram_en_d    = 1'b1;
               ram_we_d    = 1'b1;
               ram_wdata_d = (ram_rdata & ~lane_mask) | (wdata_q & lane_mask);
            end else begin
               state_d = S_ACK;
               ack_d   = 1'b1;
               case (be_q)
                  2'b01:   rdata_d = {8'h00, ram_rdata[7:0]};
                  2'b10:   rdata_d = {8'h00, ram_rdata[15:8]};
                  default: rdata_d = ram_rdata;
               endcase
            end
         end
         S_WRITE: begin
            state_d = S_ACK;
            ack_d   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 3'd0;
         be_q        <= 2'b00;
         we_q        <= 1'b0;
         wdata_q     <= 16'h0000;
         rdata_q     <= 16'h0000;
         addr_q      <= '0;
         ram_wdata_q <= 16'h0000;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         be_q        <= be_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         addr_q      <= addr_d;
         ram_wdata_q <= ram_wdata_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
      end
   end

   assign cpu_rdata = rdata_q;
   assign cpu_ack   = ack_q;
   assign cpu_busy  = busy_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_rmw_seq.sv
// Bench for mem_rmw_seq: two instances (RAM_LAT 1 and 3), each with its own RAM model and expected-memory model.
module tb_mem_rmw_seq;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        clr;
   logic        req[2];
   logic [15:0] addr[2];
   logic [1:0]  be[2];
   logic        we[2];
   logic [15:0] wdata[2];
   logic [15:0] rdata[2];
   logic        ack[2];
   logic        busy[2];
   logic        ren[2];
   logic        rwe[2];
   logic [14:0] raddr[2];
   logic [15:0] rwdata[2];
   logic [15:0] rrdata[2];

   logic [15:0] mem[2][256];
   logic [15:0] pipe[2][8];
   int          rd_cnt[2];
   int          wr_cnt[2];
   int          addr_bad[2];
   logic        pl_en[2];
   logic [7:0]  pl_addr;
   logic [15:0] pl_dat;
   logic [14:0] exp_wa[2];

   logic [15:0] ref_mem[2][256];
   logic [15:0] exp_rd[2];
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_rmw_seq #(.AW(16), .RAM_LAT((g == 0) ? LAT0 : LAT1)) dut (
         .clk(clk), .reset(reset), .cpu_req(req[g]), .cpu_addr(addr[g]), .cpu_be(be[g]),
         .cpu_we(we[g]), .cpu_wdata(wdata[g]), .cpu_rdata(rdata[g]), .cpu_ack(ack[g]),
         .cpu_busy(busy[g]), .ram_en(ren[g]), .ram_we(rwe[g]), .ram_addr(raddr[g]),
         .ram_wdata(rwdata[g]), .ram_rdata(rrdata[g]));
   end

   assign rrdata[0] = pipe[0][LAT0-1];
   assign rrdata[1] = pipe[1][LAT1-1];

   // synchronous RAM with a read pipeline of RAM_LAT stages; non-read slots carry garbage
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (clr) begin
            for (int i = 0; i < 256; i++) mem[k][i] <= 16'h0000;
            rd_cnt[k] <= 0; wr_cnt[k] <= 0; addr_bad[k] <= 0;
         end else begin
            if (pl_en[k]) mem[k][pl_addr] <= pl_dat;
            else if (ren[k] && rwe[k]) mem[k][raddr[k][7:0]] <= rwdata[k];
            if (ren[k] && !rwe[k]) rd_cnt[k] <= rd_cnt[k] + 1;
            if (ren[k] && rwe[k]) wr_cnt[k] <= wr_cnt[k] + 1;
            if (ren[k] && raddr[k] != exp_wa[k]) addr_bad[k] <= addr_bad[k] + 1;
         end
         pipe[k][0] <= (ren[k] && !rwe[k]) ? mem[k][raddr[k][7:0]] : 16'hdead;
         for (int i = 1; i < 8; i++) pipe[k][i] <= pipe[k][i-1];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_zero(input int k, input string tag);
      chk({tag, " rdata"}, 32'(rdata[k]), 32'h0);
      chk({tag, " ack/busy/en/we"}, {28'h0, ack[k], busy[k], ren[k], rwe[k]}, 32'h0);
      chk({tag, " ram_addr"}, 32'(raddr[k]), 32'h0);
      chk({tag, " ram_wdata"}, 32'(rwdata[k]), 32'h0);
   endtask

   task automatic preload(input int k, input int w, input logic [15:0] d);
      @(negedge clk);
      pl_en[k] = 1'b1; pl_addr = 8'(w); pl_dat = d;
      @(negedge clk);
      pl_en[k] = 1'b0;
      ref_mem[k][w] = d;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge in the idle cycle after ACK.
   task automatic do_txn(input int k, input logic [15:0] a, input logic [1:0] b, input bit w,
                         input logic [15:0] d, input bit noise, output int lat, output logic [15:0] rd_out);
      int          lat_exp, rds_exp, wrs_exp, rd0, wr0, bad0;
      logic [7:0]  wi;
      logic [15:0] old, mask;
      bit          busy_ok;
      wi   = a[8:1];
      old  = ref_mem[k][wi];
      mask = {{8{b[1]}}, {8{b[0]}}};
      if (b == 2'b00) lat_exp = 1;
      else if (w && b == 2'b11) lat_exp = 2;
      else if (!w) lat_exp = 2 + ((k == 0) ? LAT0 : LAT1);
      else lat_exp = 3 + ((k == 0) ? LAT0 : LAT1);
      rds_exp = (b != 2'b00 && !(w && b == 2'b11)) ? 1 : 0;
      wrs_exp = (b != 2'b00 && w) ? 1 : 0;
      if (b != 2'b00 && w) ref_mem[k][wi] = (old & ~mask) | (d & mask);
      if (b != 2'b00 && !w) exp_rd[k] = (b == 2'b11) ? old : (b == 2'b01) ? {8'h00, old[7:0]} : {8'h00, old[15:8]};
      exp_wa[k] = a[15:1];
      rd0 = rd_cnt[k]; wr0 = wr_cnt[k]; bad0 = addr_bad[k];
      req[k] = 1'b1; addr[k] = a; be[k] = b; we[k] = w; wdata[k] = d;
      @(posedge clk);
      lat = 0; busy_ok = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (!busy[k]) busy_ok = 1'b0;
         if (ack[k]) begin lat = n; break; end
         req[k] = noise ? 1'($urandom) : 1'b0;
         if (noise) begin
            addr[k] = 16'($urandom); be[k] = 2'($urandom); we[k] = 1'($urandom); wdata[k] = 16'($urandom);
         end
      end
      req[k] = 1'b0;
      rd_out = rdata[k];
      chk("ack latency", 32'(lat), 32'(lat_exp));
      chk("busy until ack", {31'h0, busy_ok}, 32'h1);
      chk("cpu_rdata", 32'(rdata[k]), 32'(exp_rd[k]));
      @(negedge clk);
      chk("idle after ack", {30'h0, ack[k], busy[k]}, 32'h0);
      chk("ram read strobes", 32'(rd_cnt[k] - rd0), 32'(rds_exp));
      chk("ram write strobes", 32'(wr_cnt[k] - wr0), 32'(wrs_exp));
      chk("ram_addr during strobe", 32'(addr_bad[k] - bad0), 32'h0);
      chk("ram word", 32'(mem[k][wi]), 32'(ref_mem[k][wi]));
   endtask

   typedef struct {
      int          k;
      bit          pre;
      int          pa;
      logic [15:0] pd;
      logic [15:0] a;
      logic [1:0]  b;
      bit          w;
      logic [15:0] d;
      bit          noise;
      int          lat;
      int          wa;
      logic [15:0] word;
      logic [15:0] rd;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int          lat, k, wa;
      logic [15:0] rd_out;
      logic [1:0]  rb;
      int          wr0, acks;

      tbl[0]  = '{0, 1, 2, 16'h1234, 16'd4, 2'b01, 1, 16'h00bb, 0, 4, 2, 16'h12bb, 16'h0000};
      tbl[1]  = '{0, 1, 2, 16'h1234, 16'd4, 2'b10, 1, 16'hcc00, 0, 4, 2, 16'hcc34, 16'h0000};
      tbl[2]  = '{0, 1, 2, 16'haabb, 16'd4, 2'b10, 0, 16'h0000, 0, 3, 2, 16'haabb, 16'h00aa};
      tbl[3]  = '{0, 0, 0, 16'h0000, 16'd4, 2'b01, 0, 16'h0000, 0, 3, 2, 16'haabb, 16'h00bb};
      tbl[4]  = '{0, 0, 0, 16'h0000, 16'd5, 2'b11, 0, 16'h0000, 0, 3, 2, 16'haabb, 16'haabb};
      tbl[5]  = '{0, 0, 0, 16'h0000, 16'd6, 2'b11, 1, 16'hbeef, 0, 2, 3, 16'hbeef, 16'haabb};
      tbl[6]  = '{0, 0, 0, 16'h0000, 16'd6, 2'b00, 1, 16'h1111, 0, 1, 3, 16'hbeef, 16'haabb};
      tbl[7]  = '{0, 0, 0, 16'h0000, 16'd7, 2'b00, 0, 16'h0000, 0, 1, 3, 16'hbeef, 16'haabb};
      tbl[8]  = '{1, 1, 2, 16'h1234, 16'd4, 2'b01, 1, 16'h55bb, 1, 6, 2, 16'h12bb, 16'h0000};
      tbl[9]  = '{1, 0, 0, 16'h0000, 16'd4, 2'b11, 0, 16'h0000, 1, 5, 2, 16'h12bb, 16'h12bb};
      tbl[10] = '{1, 0, 0, 16'h0000, 16'd4, 2'b10, 1, 16'h77ff, 1, 6, 2, 16'h77bb, 16'h12bb};
      tbl[11] = '{1, 0, 0, 16'h0000, 16'd9, 2'b11, 1, 16'hcafe, 0, 2, 4, 16'hcafe, 16'h12bb};
      tbl[12] = '{1, 0, 0, 16'h0000, 16'd4, 2'b01, 0, 16'h0000, 0, 5, 2, 16'h77bb, 16'h00bb};

      reset = 1'b1; clr = 1'b1; pl_addr = 8'h00; pl_dat = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; addr[i] = 16'h0; be[i] = 2'b00; we[i] = 1'b0; wdata[i] = 16'h0;
         pl_en[i] = 1'b0; exp_wa[i] = 15'h0; exp_rd[i] = 16'h0;
         for (int j = 0; j < 256; j++) ref_mem[i][j] = 16'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero(0, "reset i0");
      chk_zero(1, "reset i1");
      clr = 1'b0; reset = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 13; t++) begin
         if (tbl[t].pre) preload(tbl[t].k, tbl[t].pa, tbl[t].pd);
         do_txn(tbl[t].k, tbl[t].a, tbl[t].b, tbl[t].w, tbl[t].d, tbl[t].noise, lat, rd_out);
         chk($sformatf("vec%0d latency", t), 32'(lat), 32'(tbl[t].lat));
         chk($sformatf("vec%0d rdata", t), 32'(rd_out), 32'(tbl[t].rd));
         chk($sformatf("vec%0d word", t), 32'(mem[tbl[t].k][tbl[t].wa]), 32'(tbl[t].word));
      end

      // reset during the WAIT of a byte write on the RAM_LAT=3 instance
      preload(1, 5, 16'habcd);
      exp_wa[1] = 15'd5;
      wr0 = wr_cnt[1];
      req[1] = 1'b1; addr[1] = 16'd10; be[1] = 2'b01; we[1] = 1'b1; wdata[1] = 16'h1234;
      @(posedge clk);
      req[1] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_zero(1, "mid-op reset");
      reset = 1'b0;
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      acks = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (ack[1] || busy[1]) acks++;
      end
      chk("abort no ack/busy", 32'(acks), 32'h0);
      chk("abort no ram write", 32'(wr_cnt[1] - wr0), 32'h0);
      chk("abort ram unchanged", 32'(mem[1][5]), 32'habcd);

      for (int t = 0; t < 250; t++) begin
         k  = int'($urandom_range(0, 1));
         rb = 2'($urandom);
         do_txn(k, 16'($urandom_range(0, 31)), rb, 1'($urandom), 16'($urandom), 1'($urandom), lat, rd_out);
      end
      for (int kk = 0; kk < 2; kk++)
         for (wa = 0; wa < 16; wa++)
            chk($sformatf("final i%0d word%0d", kk, wa), 32'(mem[kk][wa]), 32'(ref_mem[kk][wa]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
